// File: rtl/uart_tx_fifo_param_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_tx_fifo_param_pkg;

    localparam int unsigned PARITY_NONE   = 0;
    localparam int unsigned PARITY_ODD    = 1;
    localparam int unsigned PARITY_EVEN   = 2;
    localparam int unsigned MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Unused upper data bits must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input int unsigned mode,
                                        input logic [MAX_DATA_BITS-1:0] data);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// Word-input / serial-output bundle of the UART transmitter.
interface uart_tx_fifo_param_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                 i_DV;
    logic [DATA_BITS-1:0] i_Data;
    logic                 o_Ready;
    logic                 o_Serial_Data;
    logic                 o_Sig_Active;
    logic                 o_Sig_Done;
    logic [CNT_W-1:0]     o_Fifo_Count;

    modport master (
        output i_DV, i_Data,
        input  o_Ready, o_Serial_Data, o_Sig_Active, o_Sig_Done, o_Fifo_Count
    );

    modport slave (
        input  i_DV, i_Data,
        output o_Ready, o_Serial_Data, o_Sig_Active, o_Sig_Done, o_Fifo_Count
    );
endinterface

// File: rtl/uart_tx_fifo_param_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; reset flushes contents.
module uart_tx_fifo_param_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter fed by a word FIFO; frames are sent back-to-back while words remain.
module uart_tx_fifo_param
    import uart_tx_fifo_param_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_fifo_param_if.slave  bus
);
    localparam int unsigned CYC_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_fifo_param: illegal parameter combination");
    end

    tx_state_e            state;
    logic [CYC_W-1:0]     cyc;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par;
    logic                 serial;
    logic                 active;
    logic                 done;

    logic [DATA_BITS-1:0] fifo_rd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 bit_end_c;
    logic                 stop_end_c;
    logic                 pop_c;
    logic                 next_par_c;

    assign bit_end_c  = (cyc == CYC_W'(CLKS_PER_BIT - 1));
    assign stop_end_c = (state == ST_STOP) && bit_end_c && (bit_idx == BIT_W'(STOP_BITS - 1));
    assign pop_c      = ~fifo_empty && ((state == ST_IDLE) || stop_end_c);
    assign next_par_c = parity_bit(PARITY_MODE, MAX_DATA_BITS'(fifo_rd));

    uart_tx_fifo_param_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.i_DV),
        .pop     (pop_c),
        .wr_data (bus.i_Data),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Line register follows the state of the previous cycle, so every bit keeps its full width.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cyc     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            serial  <= 1'b1;
            active  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_START:  serial <= 1'b0;
                ST_DATA:   serial <= shreg[0];
                ST_PARITY: serial <= par;
                default:   serial <= 1'b1;
            endcase

            case (state)
                ST_IDLE: begin
                    cyc     <= '0;
                    bit_idx <= '0;
                    if (pop_c) begin
                        shreg  <= fifo_rd;
                        par    <= next_par_c;
                        active <= 1'b1;
                        state  <= ST_START;
                    end
                end
                ST_START: begin
                    cyc <= bit_end_c ? '0 : cyc + CYC_W'(1);
                    if (bit_end_c) begin
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    cyc <= bit_end_c ? '0 : cyc + CYC_W'(1);
                    if (bit_end_c) begin
                        shreg <= shreg >> 1;
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    cyc <= bit_end_c ? '0 : cyc + CYC_W'(1);
                    if (bit_end_c) begin
                        bit_idx <= '0;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    cyc <= bit_end_c ? '0 : cyc + CYC_W'(1);
                    if (stop_end_c) begin
                        done    <= 1'b1;
                        bit_idx <= '0;
                        if (pop_c) begin
                            shreg <= fifo_rd;
                            par   <= next_par_c;
                            state <= ST_START;
                        end else begin
                            active <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end else if (bit_end_c) begin
                        bit_idx <= bit_idx + BIT_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Ready       = ~fifo_full;
    assign bus.o_Serial_Data = serial;
    assign bus.o_Sig_Active  = active;
    assign bus.o_Sig_Done    = done;
    assign bus.o_Fifo_Count  = fifo_count;
endmodule
